// File: rtl/uart_rx.sv
// Mid-bit sampling UART receiver: parameterised data width, optional even parity, 1 or 2 stop bits.
// Define UART_RX_SYNC_EN to put RX_dataIn through a two-flop synchronizer (adds 2 cycles of latency).
module uart_rx #(
  parameter int CLK_BITS    = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_BITS = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CLK_BITS-1:0]   clk_per_bit,
  input  logic                  RX_dataIn,
  output logic [DATA_WIDTH-1:0] RX_dataOut,
  output logic                  RX_done,
  output logic                  RX_parityError,
  output logic                  RX_frameError,
  output logic                  RX_busy
);

  localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CLK_BITS-1:0] ONE     = CLK_BITS'(1);
  localparam logic [CLK_BITS-1:0] TWO     = CLK_BITS'(2);
  localparam logic [IDX_W-1:0]    IDX_ONE = IDX_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

  state_t                r_state, w_next;
  logic [CLK_BITS-1:0]   r_cnt, r_cpb, w_cpbClamp, w_half, w_target;
  logic [IDX_W-1:0]      r_bitIdx;
  logic [DATA_WIDTH-1:0] r_shift, r_dataOut;
  logic                  r_parErr, r_stopErr, r_armed;
  logic                  r_done, r_parityError, r_frameError;
  logic                  w_line, w_tick, w_finish, w_frameErr, w_lastData;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst) r_sync <= 2'b11;
    else      r_sync <= {r_sync[0], RX_dataIn};
  end

  assign w_line = r_sync[1];
`else
  assign w_line = RX_dataIn;
`endif

  assign w_cpbClamp = (clk_per_bit < TWO) ? TWO : clk_per_bit;
  assign w_half     = r_cpb >> 1;
  assign w_target   = (r_state == START) ? (w_half - ONE) : (r_cpb - ONE);
  assign w_tick     = (r_cnt == w_target);
  assign w_lastData = (r_bitIdx == IDX_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // r_armed blocks a start until the line has been seen high, so a line held low through reset is not taken as a start bit.
  always_comb begin
    w_next     = r_state;
    w_finish   = 1'b0;
    w_frameErr = 1'b0;
    case (r_state)
      IDLE:       if (!w_line && r_armed) w_next = START;
      START:      if (w_tick) w_next = w_line ? IDLE : DATA;
      DATA:       if (w_tick && w_lastData) w_next = (PARITY_BITS == 1) ? PARITY : STOP;
      PARITY:     if (w_tick) w_next = STOP;
      STOP: begin
        if (w_tick && (r_bitIdx == IDX_W'(STOP_BITS - 1))) begin
          w_finish   = 1'b1;
          w_frameErr = r_stopErr | ~w_line;
          w_next     = w_frameErr ? BREAK_WAIT : IDLE;
        end
      end
      BREAK_WAIT: if (w_line) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_cpb         <= '0;
      r_bitIdx      <= '0;
      r_shift       <= '0;
      r_parErr      <= 1'b0;
      r_stopErr     <= 1'b0;
      r_armed       <= 1'b0;
      r_dataOut     <= '0;
      r_done        <= 1'b0;
      r_parityError <= 1'b0;
      r_frameError  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_armed <= r_armed | w_line;
      if (r_state == IDLE) begin
        if (w_next == START) begin
          r_cnt     <= '0;
          r_cpb     <= w_cpbClamp;
          r_bitIdx  <= '0;
          r_parErr  <= 1'b0;
          r_stopErr <= 1'b0;
        end
      end else if (r_state != BREAK_WAIT) begin
        r_cnt <= w_tick ? '0 : r_cnt + ONE;
      end
      if (w_tick) begin
        case (r_state)
          DATA: begin
            r_shift  <= {w_line, r_shift[DATA_WIDTH-1:1]};
            r_bitIdx <= w_lastData ? '0 : r_bitIdx + IDX_ONE;
          end
          PARITY: r_parErr <= (^r_shift) ^ w_line;
          STOP: begin
            r_stopErr <= r_stopErr | ~w_line;
            r_bitIdx  <= r_bitIdx + IDX_ONE;
          end
          default: ;
        endcase
      end
      if (w_finish) begin
        r_done        <= 1'b1;
        r_dataOut     <= r_shift;
        r_parityError <= (PARITY_BITS == 1) ? r_parErr : 1'b0;
        r_frameError  <= w_frameErr;
      end
    end
  end

  assign RX_dataOut     = r_dataOut;
  assign RX_done        = r_done;
  assign RX_parityError = r_parityError;
  assign RX_frameError  = r_frameError;
  assign RX_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8N1 instance and an 8E1 instance share clock and reset;
// stimulus pushes expected words into per-instance queues that a negedge monitor pops on RX_done.
module tb_uart_rx;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       frm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] cpb0 = 8'd16, cpb1 = 8'd16;
  logic       line0 = 1'b1, line1 = 1'b1;
  logic [7:0] dataOut0, dataOut1;
  logic       done0, done1, parErr0, parErr1, frmErr0, frmErr1, busy0, busy1;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   cycles = 0;
  int   latStart = 0;
  bit   latArmed = 1'b0;
  int   latExpected = 153;

  uart_rx #(.CLK_BITS(8), .DATA_WIDTH(8), .PARITY_BITS(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .clk_per_bit(cpb0), .RX_dataIn(line0),
    .RX_dataOut(dataOut0), .RX_done(done0), .RX_parityError(parErr0),
    .RX_frameError(frmErr0), .RX_busy(busy0)
  );

  uart_rx #(.CLK_BITS(8), .DATA_WIDTH(8), .PARITY_BITS(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .clk_per_bit(cpb1), .RX_dataIn(line1),
    .RX_dataOut(dataOut1), .RX_done(done1), .RX_parityError(parErr1),
    .RX_frameError(frmErr1), .RX_busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycles++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one frame LSB first; instance 1 also gets the given parity bit before the stop bit.
  task automatic applyStimulus(input int which, input int bitClks, input logic [7:0] data,
                               input logic parBit, input logic stopVal);
    logic bits[11];
    int   n;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    n = 9;
    if (which == 1) begin
      bits[n] = parBit;
      n++;
    end
    bits[n] = stopVal;
    n++;
    for (int i = 0; i < n; i++) begin
      if (which == 0) line0 = bits[i];
      else            line1 = bits[i];
      repeat (bitClks) @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every RX_done must match the oldest expected frame of its instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst && done0) begin
      if (latArmed) begin
        checkOutput("d0_latency", cycles - latStart, latExpected);
        latArmed = 1'b0;
      end
      if (q0.size() == 0) begin
        checkOutput("d0_unexpected_done", {24'd0, dataOut0}, 32'hFFFF_FFFF);
      end else begin
        e = q0.pop_front();
        checkOutput("d0_data", dataOut0, e.data);
        checkOutput("d0_parErr", parErr0, e.par);
        checkOutput("d0_frmErr", frmErr0, e.frm);
      end
    end
    if (rst && done1) begin
      if (q1.size() == 0) begin
        checkOutput("d1_unexpected_done", {24'd0, dataOut1}, 32'hFFFF_FFFF);
      end else begin
        e = q1.pop_front();
        checkOutput("d1_data", dataOut1, e.data);
        checkOutput("d1_parErr", parErr1, e.par);
        checkOutput("d1_frmErr", frmErr1, e.frm);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef UART_RX_SYNC_EN
    latExpected = 155;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dataOut0", dataOut0, 0);
    checkOutput("rst_done0", done0, 0);
    checkOutput("rst_parErr0", parErr0, 0);
    checkOutput("rst_frmErr0", frmErr0, 0);
    checkOutput("rst_busy0", busy0, 0);
    checkOutput("rst_busy1", busy1, 0);
    checkOutput("rst_dataOut1", dataOut1, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] back-to-back 0xA5, 0x3C");
    latStart = cycles;
    latArmed = 1'b1;
    q0.push_back('{8'hA5, 1'b0, 1'b0});
    applyStimulus(0, 16, 8'hA5, 1'b0, 1'b1);
    q0.push_back('{8'h3C, 1'b0, 1'b0});
    applyStimulus(0, 16, 8'h3C, 1'b0, 1'b1);
    repeat (32) @(posedge clk);
    #1;

    $display("[TB] 4-cycle glitch");
    line0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    line0 = 1'b1;
    checkOutput("glitch_busy_high", busy0, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("glitch_busy_low", busy0, 0);
    repeat (20) @(posedge clk);
    #1;

    $display("[TB] clk_per_bit changed mid-frame");
    q0.push_back('{8'hC3, 1'b0, 1'b0});
    fork
      applyStimulus(0, 16, 8'hC3, 1'b0, 1'b1);
      begin
        repeat (40) @(posedge clk);
        #1 cpb0 = 8'd5;
        repeat (60) @(posedge clk);
        #1 cpb0 = 8'd16;
      end
    join
    repeat (16) @(posedge clk);
    #1;

    $display("[TB] line held low for 30 bit times");
    q0.push_back('{8'h00, 1'b0, 1'b1});
    line0 = 1'b0;
    repeat (30 * 16) @(posedge clk);
    #1;
    line0 = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    q0.push_back('{8'h5A, 1'b0, 1'b0});
    applyStimulus(0, 16, 8'h5A, 1'b0, 1'b1);
    repeat (16) @(posedge clk);
    #1;

    $display("[TB] reset during data bit 3 of 0xFF");
    line0 = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    line0 = 1'b1;
    repeat (3 * 16 + 8) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midrst_dataOut0", dataOut0, 0);
    checkOutput("midrst_parErr0", parErr0, 0);
    checkOutput("midrst_frmErr0", frmErr0, 0);
    checkOutput("midrst_busy0", busy0, 0);
    checkOutput("midrst_done0", done0, 0);
    rst = 1'b1;
    repeat (16 * 6) @(posedge clk);
    #1;
    q0.push_back('{8'h81, 1'b0, 1'b0});
    applyStimulus(0, 16, 8'h81, 1'b0, 1'b1);
    repeat (16) @(posedge clk);
    #1;

    $display("[TB] clk_per_bit=1 clamps to 2");
    cpb0 = 8'd1;
    repeat (4) @(posedge clk);
    #1;
    q0.push_back('{8'h33, 1'b0, 1'b0});
    applyStimulus(0, 2, 8'h33, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;

    $display("[TB] even parity instance");
    q1.push_back('{8'h07, 1'b1, 1'b0});
    applyStimulus(1, 16, 8'h07, 1'b0, 1'b1);
    q1.push_back('{8'h07, 1'b0, 1'b0});
    applyStimulus(1, 16, 8'h07, 1'b1, 1'b1);
    q1.push_back('{8'h00, 1'b0, 1'b0});
    applyStimulus(1, 16, 8'h00, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;

    checkOutput("q0_drained", q0.size(), 0);
    checkOutput("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL expose parameter CLK_BITS, default 8, width of clk_per_bit and the bit counter.
REQ-002 The block SHALL expose parameter DATA_WIDTH, default 8, data bits per frame.
REQ-003 The block SHALL expose parameter PARITY_BITS, default 0, where 0 means no parity and 1 means one even-parity bit.
REQ-004 The block SHALL expose parameter STOP_BITS, default 1, with legal values 1 or 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the only clock, with all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port clk_per_bit, input, CLK_BITS bits: clocks per serial bit.
REQ-008 The block SHALL have port RX_dataIn, input, 1 bit: serial line, idle high.
REQ-009 The block SHALL have port RX_dataOut, output, DATA_WIDTH bits: last received word.
REQ-010 The block SHALL have port RX_done, output, 1 bit: one-cycle pulse per completed frame.
REQ-011 The block SHALL have port RX_parityError, output, 1 bit: parity mismatch flag, valid with RX_done.
REQ-012 The block SHALL have port RX_frameError, output, 1 bit: stop-bit-low flag, valid with RX_done.
REQ-013 The block SHALL have port RX_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY, STOP and BREAK_WAIT.
REQ-015 IDLE SHALL move to START on the first cycle the sampled line is 0, clear the counter, and latch clk_per_bit into an internal register used for the whole frame.
REQ-016 A latched clk_per_bit value below 2 SHALL be treated as 2.
REQ-017 START SHALL re-sample the line (clk_per_bit>>1) cycles after detection: 0 moves to DATA, and 1 is a false start that returns to IDLE with no RX_done.
REQ-018 Each later sample SHALL occur exactly clk_per_bit cycles after the previous one (mid-bit sampling).
REQ-019 DATA SHALL shift DATA_WIDTH samples LSB first, then go to PARITY if PARITY_BITS=1, else to STOP.
REQ-020 PARITY SHALL sample one bit and set the parity error when XOR(data bits, parity bit) is 1.
REQ-021 STOP SHALL sample STOP_BITS bits and set the frame error if any of them is 0.
REQ-022 RX_done SHALL pulse high for exactly one cycle, in the cycle after the final stop sample.
REQ-023 RX_dataOut, RX_parityError and RX_frameError SHALL update in that same cycle and hold until the next RX_done.
REQ-024 Latency SHALL be: for clk_per_bit=16 and 8N1, with detection at cycle T0, samples at T0+8, T0+24 … T0+136, stop at T0+152, and RX_done at T0+153.
REQ-025 After a frame with no frame error, the FSM SHALL return to IDLE in the RX_done cycle, so a start bit is accepted back-to-back.
REQ-026 After a frame error, the FSM SHALL go to BREAK_WAIT and stay there until the line is sampled 1, then go to IDLE; a held-low line SHALL yield exactly one RX_done.
REQ-027 RX_parityError SHALL be 0 at every RX_done when PARITY_BITS=0.
REQ-028 Changes to clk_per_bit mid-frame SHALL have no effect until the next start detection.

Reset
REQ-029 When rst=0 at a clock edge, the FSM SHALL go to IDLE, and the counters, the shift register and all outputs SHALL be cleared to 0.
REQ-030 A reset applied mid-frame SHALL abort the frame with no RX_done.
REQ-031 After a mid-frame reset, reception SHALL start at the next high-to-low edge seen while in IDLE.

Configuration
REQ-032 With macro UART_RX_SYNC_EN defined, RX_dataIn SHALL pass through a two-flop synchronizer reset to 1, and all timing in REQ-024 SHALL shift by +2 cycles relative to the raw pin.
REQ-033 With UART_RX_SYNC_EN undefined, the FSM SHALL sample RX_dataIn directly, with no added latency.

Verification
REQ-034 8N1 at clk_per_bit=16, sending 0xA5 then 0x3C back-to-back, SHALL give two RX_done pulses with RX_dataOut 0xA5 then 0x3C and both error flags 0.
REQ-035 A low glitch of 4 cycles at clk_per_bit=16 SHALL produce no RX_done and return RX_busy to 0 within 9 cycles.
REQ-036 With PARITY_BITS=1, sending 0x07 with parity bit 0 SHALL give RX_done with RX_dataOut=0x07 and RX_parityError=1.
REQ-037 A line held low for 30 bit times SHALL give one RX_done with RX_dataOut=0x00 and RX_frameError=1; after the line returns high, a following 0x5A frame SHALL be received cleanly.
REQ-038 rst=0 asserted during data bit 3 of 0xFF, then released, SHALL give no RX_done, all outputs 0, and correct reception of the next frame 0x81.
REQ-039 With clk_per_bit=1, sending 0x33 at 2 clocks per bit SHALL give RX_dataOut=0x33 with no errors.
